dea_cipher_core: RTL and testbench

- Button-triggered 16-bit "DEA" (Data Encryption Algorithm) demo engine for the 100 MHz FPGA board.
- A debounced press of BTNstart encrypts a fixed 16-bit plaintext with an 8-bit-half Feistel network, one round per clock.
- The ciphertext is shown on the 16 LEDs and held until the next press or reset.

---
 rtl/dea_cipher_core_if.sv | 28 ++
 rtl/dea_cipher_core.sv | 161 ++++++++++++++++
 tb/tb_dea_cipher_core.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dea_cipher_core_if.sv
// Button/LED bundle for dea_cipher_core.
// The core owns the slave side: it samples BTNstart and drives LED and
// fsm_state. The board or the bench owns the master side.
// fsm_state mirrors the core state register so checkers can bind to it:
//   0 = IDLE, 1 = RUN, 2 = DONE.
// There is no valid/ready pair here. BTNstart is a raw asynchronous level.
// LED is a registered level that changes only on these events:
//   - when a run completes,
//   - when a new run is loaded (LED cleared),
//   - on reset,
//   - every round when DEA_ROUND_VIEW_EN is defined.
interface dea_cipher_core_if;
    logic        BTNstart;
    logic [15:0] LED;
    logic [1:0]  fsm_state;

    modport master (
        output BTNstart,
        input  LED,
        input  fsm_state
    );

    modport slave (
        input  BTNstart,
        output LED,
        output fsm_state
    );
endinterface

// File: rtl/dea_cipher_core.sv
// dea_cipher_core: button-triggered 16-bit Feistel demo cipher.
//
// Start path:
//   - BTNstart is synchronized with two flops, then debounced.
//   - A rising edge of the debounced level loads PLAINTEXT.
//   - The core then runs ROUNDS Feistel rounds, one round per clock.
//   - The ciphertext is latched onto LED and held until the next run or reset.
//
// Latency: LED updates ROUNDS+1 cycles after the cycle in which start_pulse is high.
//
// Optional build macro DEA_ROUND_VIEW_EN:
//   - When defined, LED shows the live {L,R} after every round during RUN.
//   - When undefined, LED reads zero throughout RUN.
module dea_cipher_core #(
    parameter logic [15:0] PLAINTEXT       = 16'hCAFE,
    parameter logic [15:0] KEY             = 16'hA5C3,
    parameter int unsigned ROUNDS          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              CLK100MHZ,
    input  logic              BTNreset,
    dea_cipher_core_if.slave  bus
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
    localparam logic [1:0]  ST_DONE = 2'd2;

    localparam logic [16:0] DEB_LIMIT  = 17'(DEBOUNCE_CYCLES);
    localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS);

    // input path state
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        db_q, db_d;
    logic        db_prev_q, db_prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_inc;
    logic        start_pulse;

    // cipher state
    logic [1:0]  state_q, state_d;
    logic [7:0]  rnd_q, rnd_d;
    logic [7:0]  l_q, l_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  rk_q, rk_d;
    logic [15:0] led_q, led_d;

    // one-round datapath
    logic [7:0]  mix;
    logic [7:0]  f_out;
    logic [7:0]  l_nx, r_nx, rk_nx;
    logic [7:0]  rnd_inc;

    // Synchronize and debounce the button, then produce a one-cycle pulse
    // on the debounced rising edge.
    // The counter only runs while the sample disagrees with the debounced
    // level, so a short glitch restarts the count from zero.
    always_comb begin
        sync1_d   = bus.BTNstart;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        cnt_d     = 16'd0;
        cnt_inc   = {1'b0, cnt_q} + 17'd1;
        if (sync2_q != db_q) begin
            if (cnt_inc == DEB_LIMIT) begin
                db_d  = ~db_q;
                cnt_d = 16'd0;
            end else begin
                cnt_d = cnt_inc[15:0];
            end
        end
        start_pulse = db_q & ~db_prev_q;
    end

    // One Feistel round: F = rotl3(R ^ rk) + rk; the key rotates left by
    // one and is mixed with the schedule constant KEY[15:8].
    always_comb begin
        mix     = r_q ^ rk_q;
        f_out   = {mix[4:0], mix[7:5]} + rk_q;
        l_nx    = r_q;
        r_nx    = l_q ^ f_out;
        rk_nx   = {rk_q[6:0], rk_q[7]} ^ KEY[15:8];
        rnd_inc = rnd_q + 8'd1;
    end

    // Control FSM.
    // IDLE/DONE load the plaintext on start_pulse; RUN steps the rounds.
    // A press during RUN is ignored.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        l_d     = l_q;
        r_d     = r_q;
        rk_d    = rk_q;
        led_d   = led_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_pulse) begin
                    state_d = ST_RUN;
                    l_d     = PLAINTEXT[15:8];
                    r_d     = PLAINTEXT[7:0];
                    rk_d    = KEY[7:0];
                    rnd_d   = 8'd0;
                    led_d   = 16'h0000;
                end
            end
            ST_RUN: begin
                l_d   = l_nx;
                r_d   = r_nx;
                rk_d  = rk_nx;
                rnd_d = rnd_inc;
`ifdef DEA_ROUND_VIEW_EN
                led_d = {l_nx, r_nx};
`else
                led_d = led_q;
`endif
                if (rnd_inc == LAST_ROUND) begin
                    state_d = ST_DONE;
                    led_d   = {l_nx, r_nx};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; BTNreset low clears everything asynchronously,
    // aborting any run in progress.
    always_ff @(posedge CLK100MHZ or negedge BTNreset) begin
        if (!BTNreset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= 16'd0;
            state_q   <= ST_IDLE;
            rnd_q     <= 8'd0;
            l_q       <= 8'd0;
            r_q       <= 8'd0;
            rk_q      <= 8'd0;
            led_q     <= 16'h0000;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            l_q       <= l_d;
            r_q       <= r_d;
            rk_q      <= rk_d;
            led_q     <= led_d;
        end
    end

    assign bus.LED       = led_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_dea_cipher_core.sv
// Bench for dea_cipher_core.
//
// Four instances cover the different parameter sets:
//   u0 = defaults (8 rounds)
//   u1 = single round, PLAINTEXT 1200, KEY 0000
//   u2 = two rounds,   PLAINTEXT 0100, KEY 0000
//   u3 = defaults with 200 rounds
//
// Checking:
//   - Drivers push every expected LED change (instance, value, cycle) into exp_q.
//   - A negedge monitor pops and compares whenever any LED changes.
//
// Timing with DEBOUNCE_CYCLES = 16:
//   - press edge      -> load at press + 19 cycles
//   - final LED value -> press + 19 + ROUNDS cycles
module tb_dea_cipher_core;

  localparam int DEB = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  // exp entry: {inst[1:0], value[15:0], cycle[31:0]}
  logic [49:0] exp_q[$];

  logic        btn   [4];
  logic [15:0] led   [4];
  logic [1:0]  st    [4];
  logic [15:0] prev  [4];
  logic [15:0] led_m [4];

  dea_cipher_core_if if0();
  dea_cipher_core_if if1();
  dea_cipher_core_if if2();
  dea_cipher_core_if if3();

  assign if0.BTNstart = btn[0];
  assign if1.BTNstart = btn[1];
  assign if2.BTNstart = btn[2];
  assign if3.BTNstart = btn[3];

  assign led[0] = if0.LED;
  assign led[1] = if1.LED;
  assign led[2] = if2.LED;
  assign led[3] = if3.LED;

  assign st[0] = if0.fsm_state;
  assign st[1] = if1.fsm_state;
  assign st[2] = if2.fsm_state;
  assign st[3] = if3.fsm_state;

  dea_cipher_core u0 (
    .CLK100MHZ (clk),
    .BTNreset  (rst_n),
    .bus       (if0.slave)
  );

  dea_cipher_core #(
    .PLAINTEXT       (16'h1200),
    .KEY             (16'h0000),
    .ROUNDS          (1),
    .DEBOUNCE_CYCLES (16)
  ) u1 (
    .CLK100MHZ (clk),
    .BTNreset  (rst_n),
    .bus       (if1.slave)
  );

  dea_cipher_core #(
    .PLAINTEXT       (16'h0100),
    .KEY             (16'h0000),
    .ROUNDS          (2),
    .DEBOUNCE_CYCLES (16)
  ) u2 (
    .CLK100MHZ (clk),
    .BTNreset  (rst_n),
    .bus       (if2.slave)
  );

  dea_cipher_core #(
    .PLAINTEXT       (16'hCAFE),
    .KEY             (16'hA5C3),
    .ROUNDS          (200),
    .DEBOUNCE_CYCLES (16)
  ) u3 (
    .CLK100MHZ (clk),
    .BTNreset  (rst_n),
    .bus       (if3.slave)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
  end

  always #5 clk = ~clk;

  initial begin
    cyc = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // reference model of the round equations
  function automatic logic [15:0] dea_ref(
    input logic [15:0] pt,
    input logic [15:0] key,
    input int          rounds
  );
    logic [7:0] l, r, rk, x, f, nl, nr;
    l  = pt[15:8];
    r  = pt[7:0];
    rk = key[7:0];
    for (int i = 0; i < rounds; i++) begin
      x  = r ^ rk;
      f  = {x[4:0], x[7:5]} + rk;
      nl = r;
      nr = l ^ f;
      rk = {rk[6:0], rk[7]} ^ key[15:8];
      l  = nl;
      r  = nr;
    end
    return {l, r};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int inst, input logic [15:0] val, input int at_cyc);
    exp_q.push_back({inst[1:0], val, at_cyc[31:0]});
    led_m[inst] = val;
  endtask

  // driver: debounced press with expected result pushed up front
  task automatic press_expect(
    input  int          inst,
    input  int          hold,
    input  logic [15:0] ct,
    input  int          rounds,
    output int          p
  );
    @(negedge clk);
    btn[inst] = 1'b1;
    p = cyc;
    if (led_m[inst] != 16'h0000) push_exp(inst, 16'h0000, p + DEB + 3);
    push_exp(inst, ct, p + DEB + 3 + rounds);
    repeat (hold) @(negedge clk);
    btn[inst] = 1'b0;
  endtask

  // driver: pulse that must not change any LED
  task automatic pulse(input int inst, input int len);
    @(negedge clk);
    btn[inst] = 1'b1;
    repeat (len) @(negedge clk);
    btn[inst] = 1'b0;
  endtask

  // driver: asynchronous reset assertion away from the clock edge
  task automatic do_reset(input int hold_cycles);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (led_m[i] != 16'h0000) push_exp(i, 16'h0000, cyc);
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_led_u%0d", i), led[i], 16'h0000);
      chk($sformatf("reset_state_u%0d", i), {14'd0, st[i]}, 16'd0);
    end
    repeat (hold_cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [49:0] e;
    for (int i = 0; i < 4; i++) begin
      if (led[i] !== prev[i]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_led_u%0d: got %h at cycle %0d, expected no change",
                   i, led[i], cyc);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("led_inst_u%0d", i), 16'(i), {14'd0, e[49:48]});
          chk($sformatf("led_val_u%0d", i), led[i], e[47:32]);
          chk($sformatf("led_cyc_u%0d", i), 16'(cyc), e[15:0]);
        end
        prev[i] = led[i];
      end
    end
  end

  initial begin
    logic [15:0] ct_def;
    logic [15:0] ct_200;
    int p;

    n_vec  = 0;
    n_err  = 0;
    ct_def = dea_ref(16'hCAFE, 16'hA5C3, 8);
    ct_200 = dea_ref(16'hCAFE, 16'hA5C3, 200);
    for (int i = 0; i < 4; i++) begin
      btn[i]   = 1'b0;
      prev[i]  = 16'h0000;
      led_m[i] = 16'h0000;
    end

    // 1. reset with the button toggling, then 1 us idle
    rst_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) btn[i] = k[0];
      #10;
    end
    for (int i = 0; i < 4; i++) begin
      btn[i] = 1'b0;
      chk($sformatf("init_led_u%0d", i), led[i], 16'h0000);
      chk($sformatf("init_state_u%0d", i), {14'd0, st[i]}, 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("idle_led_u%0d", i), led[i], 16'h0000);

    // 2. single round: 1200 -> 0012
    press_expect(1, 70, 16'h0012, 1, p);
    repeat (30) @(negedge clk);
    chk("one_round_led", led[1], 16'h0012);

    // 3. two rounds: 0100 -> 0108
    press_expect(2, 70, 16'h0108, 2, p);
    repeat (30) @(negedge clk);
    chk("two_round_led", led[2], 16'h0108);

    // 4. glitches ignored, then two full presses on the default instance
    pulse(0, 5);
    repeat (40) @(negedge clk);
    pulse(0, 12);
    repeat (40) @(negedge clk);
    chk("glitch_led", led[0], 16'h0000);
    chk("glitch_state", {14'd0, st[0]}, 16'd0);
    press_expect(0, 70, ct_def, 8, p);
    repeat (40) @(negedge clk);
    chk("default_ct", led[0], ct_def);
    press_expect(0, 70, ct_def, 8, p);
    repeat (40) @(negedge clk);
    chk("default_ct_repeat", led[0], ct_def);

    // 5. reset 50 cycles after start_pulse on the 200-round instance
    press_expect(3, 30, 16'h0000, 0, p);
    void'(exp_q.pop_back());   // run is aborted; no completion expected
    led_m[3] = 16'h0000;
    wait_until(p + DEB + 2 + 49);
    chk("midrun_state_run", {14'd0, st[3]}, 16'd1);
    do_reset(3);
    repeat (10) @(negedge clk);
    press_expect(3, 30, ct_200, 200, p);
    wait_until(p + DEB + 3 + 200 + 5);
    chk("after_reset_ct", led[3], ct_200);
    chk("after_reset_state_done", {14'd0, st[3]}, 16'd2);

    // 6. second press during RUN is ignored
    do_reset(3);
    repeat (10) @(negedge clk);
    press_expect(3, 30, ct_200, 200, p);
    wait_until(p + 60);
    pulse(3, 30);
    wait_until(p + DEB + 3 + 200 + 10);
    chk("ignored_restart_ct", led[3], ct_200);
    chk("ignored_restart_state", {14'd0, st[3]}, 16'd2);

    repeat (20) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
